me_window_loader: RTL and testbench

//  Upstream feeder for the motion-estimation core (me). It takes a raster pixel stream and stores it in banked RAMs:

---
 rtl/me_window_loader_pkg.sv | 28 ++
 rtl/me_window_loader_if.sv | 39 +++
 rtl/me_bank_ram.sv | 41 ++++
 rtl/me_window_loader.sv | 195 +++++++++++++++++++
 tb/tb_me_window_loader.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/me_window_loader_pkg.sv
// ============================================================================
// Module      : me_pkg
// Description : Shared geometry constants and loader state encoding for the
//               motion-estimation window loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package me_pkg;

  localparam int MACRO_DIM  = 16;
  localparam int SEARCH_DIM = 48;
  localparam int PORT_WIDTH = MACRO_DIM + 1;
  localparam int NSTRIP     = (SEARCH_DIM + PORT_WIDTH - 1) / PORT_WIDTH;
  localparam int RD_AW      = 8;
  localparam int CUR_DEPTH  = MACRO_DIM;
  localparam int SRCH_DEPTH = SEARCH_DIM * NSTRIP;

  typedef enum logic [1:0] {
    LOAD_CUR  = 2'd0,
    LOAD_SRCH = 2'd1,
    RUN       = 2'd2,
    REPORT    = 2'd3
  } ld_state_t;

endpackage

`default_nettype wire

// File: rtl/me_window_loader_if.sv
// ============================================================================
// Module      : me_window_loader_if
// Description : Pixel stream, motion-estimation read ports, start/done
//               handshake and SAD report of the window loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface me_window_loader_if;
  import me_pkg::*;

  logic             pix_valid;
  logic [7:0]       pix_data;
  logic             pix_ready;
  logic             me_start;
  logic [RD_AW-1:0] me_addr;
  logic [7:0]       me_cpr [0:MACRO_DIM-1];
  logic [7:0]       me_spr [0:PORT_WIDTH-1];
  logic             me_done;
  logic [15:0]      me_min_sad;
  logic             sad_valid;
  logic [15:0]      sad;
  logic             busy;

  // Loader side
  modport master (
    input  pix_valid, pix_data, me_addr, me_done, me_min_sad,
    output pix_ready, me_start, me_cpr, me_spr, sad_valid, sad, busy
  );

  // Environment side (pixel source, me core, mode decision)
  modport slave (
    output pix_valid, pix_data, me_addr, me_done, me_min_sad,
    input  pix_ready, me_start, me_cpr, me_spr, sad_valid, sad, busy
  );

endinterface

`default_nettype wire

// File: rtl/me_bank_ram.sv
// ============================================================================
// Module      : me_bank_ram
// Description : One pixel bank: single synchronous write port, one
//               asynchronous read port. Reads past DEPTH return zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module me_bank_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = 8,
  parameter int WAW   = $clog2(DEPTH)
) (
  input  wire logic           clk,
  input  wire logic           we,
  input  wire logic [WAW-1:0] waddr,
  input  wire logic [7:0]     wdata,
  input  wire logic [AW-1:0]  raddr,
  output logic      [7:0]     rdata
);

  logic [7:0] mem [DEPTH];

  // Write port; storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Same-cycle read, zero outside the populated range
  always_comb begin
    rdata = 8'd0;
    if (32'(raddr) < DEPTH) begin
      rdata = mem[raddr[WAW-1:0]];
    end
  end

endmodule

`default_nettype wire

// File: rtl/me_window_loader.sv
// ============================================================================
// Module      : me_window_loader
// Description : Loads one current macroblock and one search window from a
//               raster pixel stream into column banks, serves the me read
//               ports, runs the me start/done handshake and latches min SAD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module me_window_loader
  import me_pkg::*;
(
  input wire logic           clk,
  input wire logic           rst_n,
  me_window_loader_if.master bus
);

  // Counter widths: $clog2 of (terminal value + 1)
  localparam int CUR_W   = $clog2(MACRO_DIM);
  localparam int SROW_W  = $clog2(SEARCH_DIM);
  localparam int SCOL_W  = $clog2(SEARCH_DIM);
  localparam int BANK_W  = $clog2(PORT_WIDTH);
  localparam int STRIP_W = (NSTRIP > 1) ? $clog2(NSTRIP) : 1;
  localparam int SWAW    = $clog2(SRCH_DEPTH);

  ld_state_t state, state_nxt;

  logic               ready_en;
  logic [CUR_W-1:0]   cur_col, cur_row;
  logic [SROW_W-1:0]  srch_row;
  logic [SCOL_W-1:0]  srch_col;
  logic [BANK_W-1:0]  srch_bank;
  logic [STRIP_W-1:0] srch_strip;
  logic [15:0]        sad_q;

  logic                  load_st;
  logic                  xfer;
  logic                  cur_last;
  logic                  srch_col_last;
  logic                  srch_last;
  logic                  bank_last;
  logic [SWAW-1:0]       srch_waddr;
  logic [MACRO_DIM-1:0]  cur_we;
  logic [PORT_WIDTH-1:0] srch_we;

  assign xfer          = bus.pix_valid & bus.pix_ready;
  assign cur_last      = (cur_col == CUR_W'(MACRO_DIM - 1)) && (cur_row == CUR_W'(MACRO_DIM - 1));
  assign srch_col_last = (srch_col == SCOL_W'(SEARCH_DIM - 1));
  assign srch_last     = srch_col_last && (srch_row == SROW_W'(SEARCH_DIM - 1));
  assign bank_last     = (srch_bank == BANK_W'(PORT_WIDTH - 1));
  // Strip base is a constant multiple; no division needed anywhere
  assign srch_waddr    = SWAW'(srch_strip) * SWAW'(SEARCH_DIM) + SWAW'(srch_row);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD_CUR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and state-decoded outputs
  always_comb begin
    state_nxt     = state;
    load_st       = 1'b0;
    bus.me_start  = 1'b0;
    bus.sad_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      LOAD_CUR: begin
        load_st = 1'b1;
        if (xfer && cur_last) state_nxt = LOAD_SRCH;
      end
      LOAD_SRCH: begin
        load_st = 1'b1;
        if (xfer && srch_last) state_nxt = RUN;
      end
      RUN: begin
        bus.me_start = 1'b1;
        bus.busy     = 1'b1;
        if (bus.me_done) state_nxt = REPORT;
      end
      REPORT: begin
        bus.sad_valid = 1'b1;
        bus.busy      = 1'b1;
        state_nxt     = LOAD_CUR;
      end
      default: state_nxt = LOAD_CUR;
    endcase
  end

  // Holds pix_ready low while in reset, enables it from the first edge after
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
    end else begin
      ready_en <= 1'b1;
    end
  end

  assign bus.pix_ready = ready_en & load_st;

  // Current-macroblock raster position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_col <= '0;
      cur_row <= '0;
    end else if (xfer && state == LOAD_CUR) begin
      if (cur_col == CUR_W'(MACRO_DIM - 1)) begin
        cur_col <= '0;
        cur_row <= cur_last ? '0 : cur_row + 1'b1;
      end else begin
        cur_col <= cur_col + 1'b1;
      end
    end
  end

  // Search-window raster position tracked as row, column, bank and strip
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srch_row   <= '0;
      srch_col   <= '0;
      srch_bank  <= '0;
      srch_strip <= '0;
    end else if (xfer && state == LOAD_SRCH) begin
      if (srch_col_last) begin
        srch_col   <= '0;
        srch_bank  <= '0;
        srch_strip <= '0;
        srch_row   <= srch_last ? '0 : srch_row + 1'b1;
      end else begin
        srch_col <= srch_col + 1'b1;
        if (bank_last) begin
          srch_bank  <= '0;
          srch_strip <= srch_strip + 1'b1;
        end else begin
          srch_bank <= srch_bank + 1'b1;
        end
      end
    end
  end

  // One-hot bank write enables from the column/bank counters
  always_comb begin
    cur_we  = '0;
    srch_we = '0;
    if (xfer && state == LOAD_CUR)  cur_we[cur_col]    = 1'b1;
    if (xfer && state == LOAD_SRCH) srch_we[srch_bank] = 1'b1;
  end

  // Min SAD is captured only when me finishes during RUN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sad_q <= '0;
    end else if (state == RUN && bus.me_done) begin
      sad_q <= bus.me_min_sad;
    end
  end

  assign bus.sad = sad_q;

  generate
    for (genvar l = 0; l < MACRO_DIM; l++) begin : g_cur
      me_bank_ram #(
        .DEPTH (CUR_DEPTH),
        .AW    (RD_AW)
      ) u_bank (
        .clk   (clk),
        .we    (cur_we[l]),
        .waddr (cur_row),
        .wdata (bus.pix_data),
        .raddr (bus.me_addr),
        .rdata (bus.me_cpr[l])
      );
    end

    for (genvar l = 0; l < PORT_WIDTH; l++) begin : g_srch
      me_bank_ram #(
        .DEPTH (SRCH_DEPTH),
        .AW    (RD_AW)
      ) u_bank (
        .clk   (clk),
        .we    (srch_we[l]),
        .waddr (srch_waddr),
        .wdata (bus.pix_data),
        .raddr (bus.me_addr),
        .rdata (bus.me_spr[l])
      );
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_me_window_loader.sv
// ============================================================================
// Module      : tb_me_window_loader
// Description : Self-checking bench for me_window_loader with read and SAD
//               scoreboards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_me_window_loader;
  import me_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    bit         srch;
    int         lane;
    logic [7:0] val;
  } rd_exp_t;

  rd_exp_t     rd_q[$];
  logic [15:0] sad_q[$];

  me_window_loader_if bus ();

  me_window_loader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pixel value for stream index idx: first 256 are the current MB, then search
  function automatic logic [7:0] pix_val(input int idx, input int off);
    int j, r, c;
    if (idx < 256) return 8'((idx + off) % 256);
    j = idx - 256;
    r = j / 48;
    c = j % 48;
    return 8'((48 * r + c) % 256);
  endfunction

  // Streams until n pixels are accepted, then extra cycles of random valid
  task automatic drive_pixels(input int n, input int pct, input int start_idx, input int off,
                              input int extra, output int acc, output logic ready_after);
    int  cyc;
    bit  v;
    acc = 0;
    cyc = 0;
    while (acc < n && cyc < 12000) begin
      @(negedge clk);
      cyc++;
      v = ($urandom_range(99) < pct);
      bus.pix_valid = v;
      bus.pix_data  = pix_val(start_idx + acc, off);
      if (v && bus.pix_ready === 1'b1) acc++;
    end
    @(negedge clk);
    ready_after   = bus.pix_ready;
    bus.pix_valid = 1'b0;
    for (int e = 0; e < extra; e++) begin
      v = ($urandom_range(99) < 50);
      bus.pix_valid = v;
      bus.pix_data  = 8'hEE;
      if (v && bus.pix_ready === 1'b1) acc++;
      @(negedge clk);
    end
    bus.pix_valid = 1'b0;
  endtask

  task automatic check_cur(input int a, input int off);
    rd_exp_t e;
    bus.me_addr = RD_AW'(a);
    for (int l = 0; l < MACRO_DIM; l++) begin
      e.srch = 1'b0;
      e.lane = l;
      e.val  = (a < 16) ? 8'((16 * a + l + off) % 256) : 8'h00;
      rd_q.push_back(e);
    end
    #1;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      checks++;
      if (bus.me_cpr[e.lane] !== e.val) begin
        failures++;
        $display("FAIL cur_read addr=%0d lane=%0d got=%h exp=%h", a, e.lane, bus.me_cpr[e.lane], e.val);
      end
    end
  endtask

  task automatic check_srch(input int a);
    rd_exp_t e;
    int s, r, c;
    bus.me_addr = RD_AW'(a);
    for (int l = 0; l < PORT_WIDTH; l++) begin
      e.srch = 1'b1;
      e.lane = l;
      if (a >= 144) begin
        e.val = 8'h00;
        rd_q.push_back(e);
      end else begin
        s = a / 48;
        r = a % 48;
        c = s * 17 + l;
        if (c < 48) begin
          e.val = 8'((48 * r + c) % 256);
          rd_q.push_back(e);
        end
      end
    end
    #1;
    while (rd_q.size() > 0) begin
      e = rd_q.pop_front();
      checks++;
      if (bus.me_spr[e.lane] !== e.val) begin
        failures++;
        $display("FAIL srch_read addr=%0d lane=%0d got=%h exp=%h", a, e.lane, bus.me_spr[e.lane], e.val);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.pix_ready !== 1'b0) begin failures++; $display("FAIL rst_pix_ready got=%b exp=0", bus.pix_ready); end
    checks++; if (bus.me_start !== 1'b0) begin failures++; $display("FAIL rst_me_start got=%b exp=0", bus.me_start); end
    checks++; if (bus.sad_valid !== 1'b0) begin failures++; $display("FAIL rst_sad_valid got=%b exp=0", bus.sad_valid); end
    checks++; if (bus.sad !== 16'h0) begin failures++; $display("FAIL rst_sad got=%h exp=0000", bus.sad); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", bus.busy); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL rel_pix_ready got=%b exp=1", bus.pix_ready); end
  endtask

  task automatic test_cur_load(input int off);
    int   acc;
    logic ra;
    drive_pixels(256, 100, 0, off, 0, acc, ra);
    checks++; if (acc != 256) begin failures++; $display("FAIL cur_count got=%0d exp=256", acc); end
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL cur_ready_after got=%b exp=1", ra); end
    check_cur(0, off);
    check_cur(3, off);
    check_cur(15, off);
    check_cur(200, off);
  endtask

  task automatic test_srch_load();
    int   acc;
    logic ra;
    drive_pixels(2304, 100, 256, 0, 0, acc, ra);
    checks++; if (acc != 2304) begin failures++; $display("FAIL srch_count got=%0d exp=2304", acc); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL srch_ready_after got=%b exp=0", ra); end
    checks++; if (bus.me_start !== 1'b1) begin failures++; $display("FAIL run_me_start got=%b exp=1", bus.me_start); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL run_busy got=%b exp=1", bus.busy); end
    check_srch(0);
    check_srch(53);
    check_srch(100);
    check_srch(143);
    check_srch(200);
  endtask

  task automatic test_handshake(input logic [15:0] val);
    int          cyc;
    logic [15:0] exp_sad;
    cyc = 0;
    while (bus.me_start !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checks++; if (bus.me_start !== 1'b1) begin failures++; $display("FAIL hs_start_timeout got=%b exp=1", bus.me_start); end
    repeat (10) @(negedge clk);
    checks++; if (bus.sad_valid !== 1'b0) begin failures++; $display("FAIL hs_early_valid got=%b exp=0", bus.sad_valid); end
    bus.me_done    = 1'b1;
    bus.me_min_sad = val;
    sad_q.push_back(val);
    @(negedge clk);
    bus.me_done    = 1'b0;
    bus.me_min_sad = 16'h0;
    checks++; if (bus.sad_valid !== 1'b1) begin failures++; $display("FAIL hs_sad_valid got=%b exp=1", bus.sad_valid); end
    exp_sad = sad_q.pop_front();
    checks++; if (bus.sad !== exp_sad) begin failures++; $display("FAIL hs_sad got=%h exp=%h", bus.sad, exp_sad); end
    checks++; if (bus.me_start !== 1'b0) begin failures++; $display("FAIL hs_start_drop got=%b exp=0", bus.me_start); end
    @(negedge clk);
    checks++; if (bus.sad_valid !== 1'b0) begin failures++; $display("FAIL hs_pulse_len got=%b exp=0", bus.sad_valid); end
    checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL hs_ready_next got=%b exp=1", bus.pix_ready); end
    checks++; if (bus.sad !== exp_sad) begin failures++; $display("FAIL hs_sad_hold got=%h exp=%h", bus.sad, exp_sad); end
    // me_done outside RUN must be ignored
    bus.me_done    = 1'b1;
    bus.me_min_sad = 16'hDEAD;
    @(negedge clk);
    bus.me_done    = 1'b0;
    bus.me_min_sad = 16'h0;
    checks++; if (bus.sad_valid !== 1'b0) begin failures++; $display("FAIL stray_done_valid got=%b exp=0", bus.sad_valid); end
    checks++; if (bus.sad !== exp_sad) begin failures++; $display("FAIL stray_done_sad got=%h exp=%h", bus.sad, exp_sad); end
    checks++; if (bus.pix_ready !== 1'b1) begin failures++; $display("FAIL stray_done_ready got=%b exp=1", bus.pix_ready); end
  endtask

  task automatic test_backpressure();
    int   acc;
    logic ra;
    drive_pixels(2560, 50, 0, 0, 40, acc, ra);
    checks++; if (acc != 2560) begin failures++; $display("FAIL bp_count got=%0d exp=2560", acc); end
    checks++; if (ra !== 1'b0) begin failures++; $display("FAIL bp_ready_after got=%b exp=0", ra); end
    check_cur(7, 0);
    check_srch(53);
    check_srch(120);
    test_handshake(16'hBEEF);
  endtask

  task automatic test_reset_mid();
    int   acc;
    logic ra;
    drive_pixels(256, 100, 0, 0, 0, acc, ra);
    drive_pixels(1000, 100, 256, 0, 0, acc, ra);
    checks++; if (acc != 1000) begin failures++; $display("FAIL mid_count got=%0d exp=1000", acc); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.pix_ready !== 1'b0) begin failures++; $display("FAIL mid_rst_ready got=%b exp=0", bus.pix_ready); end
    checks++; if (bus.sad !== 16'h0) begin failures++; $display("FAIL mid_rst_sad got=%h exp=0000", bus.sad); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_pixels(256, 100, 0, 128, 0, acc, ra);
    checks++; if (ra !== 1'b1) begin failures++; $display("FAIL mid_cur_ready got=%b exp=1", ra); end
    checks++; if (bus.me_start !== 1'b0) begin failures++; $display("FAIL mid_cur_start got=%b exp=0", bus.me_start); end
    check_cur(3, 128);
    check_cur(12, 128);
    drive_pixels(2304, 100, 256, 0, 0, acc, ra);
    checks++; if (acc != 2304) begin failures++; $display("FAIL mid_srch_count got=%0d exp=2304", acc); end
    check_srch(53);
    check_srch(10);
    test_handshake(16'h0F0F);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    bus.pix_valid  = 1'b0;
    bus.pix_data   = 8'h00;
    bus.me_addr    = '0;
    bus.me_done    = 1'b0;
    bus.me_min_sad = 16'h0;
    test_reset();
    test_cur_load(0);
    test_srch_load();
    test_handshake(16'h1234);
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
